dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and constants for the data-memory responder
package dmem_pkg;

  // Responder sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;

  // Width of the latency and write-buffer down-counters
  localparam int CNT_W = 4;

  // Legal programmable latency range, in cycles
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  function automatic bit latency_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port DEPTH x 16 synchronous read/write storage, no reset
module dmem_array #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  // Write on enabled store; read data register only updates on an enabled load
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory responder with programmable latency; DMEM_WBUF_EN adds a posted-store buffer
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [15:0] addr,
  input  logic [15:0] sdata,
  output logic [15:0] ldata,
  output logic        stall,
  output logic        wbuf_busy
);

  // Reject illegal configurations at elaboration
  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("dmem_responder: DEPTH must equal 2**ADDR_W");
  end

  localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dmem_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              kind_store;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       sdata_q;
  logic [15:0]       ldata_q;

  logic              req;
  logic              stall_c;
  logic              acc_start;
  logic              post;
  logic              wbuf_block;
  logic              post_ok;

  logic              arr_en, arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [15:0]       arr_wdata;
  logic [15:0]       arr_rdata;

  // Upper address bits alias away by truncation
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[15:ADDR_W];

  assign req = re_mem | we_mem;

`ifdef DMEM_WBUF_EN
  logic              wb_busy;
  logic [CNT_W-1:0]  wb_cnt;
  logic [ADDR_W-1:0] wb_addr;
  logic [15:0]       wb_data;
  logic              wb_commit;

  assign wbuf_block = wb_busy;
  assign post_ok    = we_mem & ~wb_busy;
  assign wb_commit  = wb_busy & (wb_cnt == CNT_ONE);
  assign wbuf_busy  = wb_busy;

  // Posted store buffer: capture, count down LATENCY cycles, commit and free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_busy <= 1'b0;
      wb_cnt  <= '0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (post) begin
      wb_busy <= 1'b1;
      wb_cnt  <= CNT_W'(LATENCY);
      wb_addr <= addr[ADDR_W-1:0];
      wb_data <= sdata;
    end else if (wb_busy) begin
      wb_cnt <= wb_cnt - CNT_ONE;
      if (wb_cnt == CNT_ONE) begin
        wb_busy <= 1'b0;
      end
    end
  end
`else
  assign wbuf_block = 1'b0;
  assign post_ok    = 1'b0;
  assign wbuf_busy  = 1'b0;
`endif

  // Next-state, stall and array-port control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    acc_start = 1'b0;
    post      = 1'b0;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = addr_q;
    arr_wdata = sdata_q;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (wbuf_block) begin
            // Buffer still draining: hold the pipeline, accept nothing yet
            stall_c = 1'b1;
          end else if (post_ok) begin
            post = 1'b1;
          end else begin
            stall_c   = 1'b1;
            acc_start = 1'b1;
            if (LATENCY == 1) begin
              // Single-cycle latency: access happens at the acceptance edge
              state_nxt = ST_DONE;
              arr_en    = 1'b1;
              arr_we    = we_mem;
              arr_addr  = addr[ADDR_W-1:0];
              arr_wdata = sdata;
            end else begin
              state_nxt = ST_BUSY;
              cnt_nxt   = LAT_M1;
            end
          end
        end
      end
      ST_BUSY: begin
        // cnt holds the stall cycles still to run, this one included
        stall_c = 1'b1;
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          arr_en    = 1'b1;
          arr_we    = kind_store;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
`ifdef DMEM_WBUF_EN
    // Drain only runs while the FSM is parked in IDLE, so the port is free
    if (wb_commit) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_addr  = wb_addr;
      arr_wdata = wb_data;
    end
`endif
  end

  assign stall = stall_c & rst_n;

  // FSM state and latency counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Latch the accepted request so inputs can be ignored while busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind_store <= 1'b0;
      addr_q     <= '0;
      sdata_q    <= '0;
    end else if (acc_start) begin
      kind_store <= we_mem;
      addr_q     <= addr[ADDR_W-1:0];
      sdata_q    <= sdata;
    end
  end

  // Hold the last completed load value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ldata_q <= 16'h0000;
    end else if (state == ST_DONE && !kind_store) begin
      ldata_q <= arr_rdata;
    end
  end

  // In DONE of a load the array read register already carries the word
  assign ldata = (state == ST_DONE && !kind_store) ? arr_rdata : ldata_q;

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .en   (arr_en & rst_n),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder (LATENCY=2 and LATENCY=1), optional DMEM_WBUF_EN checks
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re_mem, we_mem, re1, we1;
  logic [15:0] addr, sdata, addr1, sdata1;
  logic [15:0] ldata, ldata1;
  logic        stall, stall1, wbuf_busy, wbuf_busy1;

  int total = 0;
  int bad   = 0;

`ifdef DMEM_WBUF_EN
  localparam int ST_NS2 = 0;
  localparam int ST_NS1 = 0;
  localparam logic WB_AFTER = 1'b1;
`else
  localparam int ST_NS2 = 2;
  localparam int ST_NS1 = 1;
  localparam logic WB_AFTER = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2), .ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .re_mem(re_mem), .we_mem(we_mem), .addr(addr),
    .sdata(sdata), .ldata(ldata), .stall(stall), .wbuf_busy(wbuf_busy)
  );

  dmem_responder #(.LATENCY(1), .ADDR_W(10), .DEPTH(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .re_mem(re1), .we_mem(we1), .addr(addr1),
    .sdata(sdata1), .ldata(ldata1), .stall(stall1), .wbuf_busy(wbuf_busy1)
  );

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request, hold it while stalled (bounded), let it retire, then drop it
  task automatic access(input int which, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        output int ns, output logic [15:0] ld);
    if (which == 0) begin
      re_mem = r; we_mem = w; addr = a; sdata = d;
    end else begin
      re1 = r; we1 = w; addr1 = a; sdata1 = d;
    end
    ns = 0;
    #1;
    while (((which == 0) ? stall : stall1) && ns < 64) begin
      ns++;
      @(posedge clk);
      #1;
    end
    ld = (which == 0) ? ldata : ldata1;
    @(posedge clk);
    #1;
    if (which == 0) begin
      re_mem = 1'b0; we_mem = 1'b0;
    end else begin
      re1 = 1'b0; we1 = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    re_mem = 1'b1; we_mem = 1'b0; addr = 16'h0001; sdata = 16'h0000;
    re1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; sdata1 = 16'h0000;
    @(posedge clk);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_forced got=%b exp=0", stall); end
    @(posedge clk);
    #1;
    total++;
    if (ldata !== 16'h0000) begin bad++; $display("FAIL reset_ldata got=%h exp=0000", ldata); end
    total++;
    if (wbuf_busy !== 1'b0) begin bad++; $display("FAIL reset_wbuf got=%b exp=0", wbuf_busy); end
    total++;
    if (ldata1 !== 16'h0000 || stall1 !== 1'b0) begin
      bad++; $display("FAIL reset_lat1 got=%h/%b exp=0000/0", ldata1, stall1);
    end
    re_mem = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b exp=0", stall); end
    cycles(1);
  endtask

  task automatic test_store_load;
    int ns;
    logic [15:0] ld;
    access(0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, ns, ld);
    total++;
    if (ns != ST_NS2) begin bad++; $display("FAIL store_stall_cycles got=%0d exp=%0d", ns, ST_NS2); end
    total++;
    if (wbuf_busy !== WB_AFTER) begin bad++; $display("FAIL store_wbuf got=%b exp=%b", wbuf_busy, WB_AFTER); end
    cycles(3);
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, ns, ld);
    total++;
    if (ns != 2) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=2", ns); end
    total++;
    if (ld !== 16'hBEEF) begin bad++; $display("FAIL load_data got=%h exp=beef", ld); end
    cycles(2);
    total++;
    if (ldata !== 16'hBEEF) begin bad++; $display("FAIL load_hold got=%h exp=beef", ldata); end
  endtask

  task automatic test_alias_priority;
    int ns;
    logic [15:0] ld;
    access(0, 1'b0, 1'b1, 16'h0405, 16'h1234, ns, ld);
    cycles(3);
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, ns, ld);
    total++;
    if (ld !== 16'h1234) begin bad++; $display("FAIL alias_load got=%h exp=1234", ld); end
    access(0, 1'b1, 1'b1, 16'h0005, 16'h00AA, ns, ld);
    total++;
    if (ns != ST_NS2) begin bad++; $display("FAIL both_as_store_stall got=%0d exp=%0d", ns, ST_NS2); end
    cycles(3);
    total++;
    if (ldata !== 16'h1234) begin bad++; $display("FAIL store_keeps_ldata got=%h exp=1234", ldata); end
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, ns, ld);
    total++;
    if (ld !== 16'h00AA) begin bad++; $display("FAIL both_wrote got=%h exp=00aa", ld); end
  endtask

  task automatic test_reset_mid_store;
    int ns;
    logic [15:0] ld;
    access(0, 1'b0, 1'b1, 16'h0003, 16'h0000, ns, ld);
    cycles(3);
`ifdef DMEM_WBUF_EN
    access(0, 1'b0, 1'b1, 16'h0003, 16'hFFFF, ns, ld);
    rst_n = 1'b0;
    #1;
`else
    we_mem = 1'b1; addr = 16'h0003; sdata = 16'hFFFF;
    cycles(1);
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL busy_stall got=%b exp=1", stall); end
    rst_n = 1'b0;
    #1;
`endif
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL rst_forces_stall got=%b exp=0", stall); end
    @(posedge clk);
    #1;
    we_mem = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || wbuf_busy !== 1'b0) begin
      bad++; $display("FAIL after_reset got=%b/%b exp=0/0", stall, wbuf_busy);
    end
    cycles(3);
    access(0, 1'b1, 1'b0, 16'h0003, 16'h0000, ns, ld);
    total++;
    if (ld !== 16'h0000) begin bad++; $display("FAIL aborted_store got=%h exp=0000", ld); end
  endtask

  task automatic test_latency1;
    int ns;
    logic [15:0] ld;
    access(1, 1'b0, 1'b1, 16'h0007, 16'h5A5A, ns, ld);
    total++;
    if (ns != ST_NS1) begin bad++; $display("FAIL lat1_store_stall got=%0d exp=%0d", ns, ST_NS1); end
    cycles(3);
    access(1, 1'b1, 1'b0, 16'h0007, 16'h0000, ns, ld);
    total++;
    if (ns != 1) begin bad++; $display("FAIL lat1_load_stall got=%0d exp=1", ns); end
    total++;
    if (ld !== 16'h5A5A) begin bad++; $display("FAIL lat1_load_data got=%h exp=5a5a", ld); end
    cycles(1);
    total++;
    if (ldata1 !== 16'h5A5A) begin bad++; $display("FAIL lat1_hold got=%h exp=5a5a", ldata1); end
  endtask

`ifdef DMEM_WBUF_EN
  task automatic test_wbuf;
    int ns;
    int n;
    logic [15:0] ld;
    access(0, 1'b0, 1'b1, 16'h0009, 16'h7777, ns, ld);
    total++;
    if (ns != 0) begin bad++; $display("FAIL wbuf_post_stall got=%0d exp=0", ns); end
    total++;
    if (wbuf_busy !== 1'b1) begin bad++; $display("FAIL wbuf_busy_set got=%b exp=1", wbuf_busy); end
    access(0, 1'b1, 1'b0, 16'h0009, 16'h0000, ns, ld);
    total++;
    if (ns != 4) begin bad++; $display("FAIL wbuf_load_stall got=%0d exp=4", ns); end
    total++;
    if (ld !== 16'h7777) begin bad++; $display("FAIL wbuf_load_data got=%h exp=7777", ld); end
    cycles(2);
    access(0, 1'b0, 1'b1, 16'h000A, 16'h1111, ns, ld);
    access(0, 1'b0, 1'b1, 16'h000B, 16'h2222, ns, ld);
    total++;
    if (ns != 2) begin bad++; $display("FAIL wbuf_store_wait got=%0d exp=2", ns); end
    n = 0;
    while (wbuf_busy && n < 40) begin
      n++;
      cycles(1);
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL wbuf_busy_len got=%0d exp=2", n); end
    access(0, 1'b1, 1'b0, 16'h000A, 16'h0000, ns, ld);
    total++;
    if (ld !== 16'h1111) begin bad++; $display("FAIL wbuf_first got=%h exp=1111", ld); end
    access(0, 1'b1, 1'b0, 16'h000B, 16'h0000, ns, ld);
    total++;
    if (ld !== 16'h2222) begin bad++; $display("FAIL wbuf_second got=%h exp=2222", ld); end
  endtask
`endif

  initial begin
    test_reset;
    test_store_load;
    test_alias_priority;
    test_reset_mid_store;
    test_latency1;
`ifdef DMEM_WBUF_EN
    test_wbuf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
